// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: field widths, burst
// descriptor layout and the master transmit FSM encoding.
package bus_pkg;
    localparam int ADDR_WIDTH     = 12;
    localparam int DATA_WIDTH     = 8;
    localparam int BURST_WIDTH    = 13;
    localparam int BURST_EN       = 0;
    localparam int BURST_LEN_LSB  = 1;
    localparam int BURST_LEN_MSB  = BURST_WIDTH - 1;
    localparam int BEAT_CNT_WIDTH = BURST_LEN_MSB - BURST_LEN_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND,
        ST_BURST_REQ,
        ST_BURST_SEND,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic                  read;
    } req_t;

    // Number of extra beats that follow the first one.
    function automatic logic [BEAT_CNT_WIDTH-1:0] burst_len(input logic [BURST_WIDTH-1:0] b);
        return b[BURST_LEN_MSB:BURST_LEN_LSB];
    endfunction
endpackage

// File: rtl/master_out_port_if.sv
// Serial bus lines between the master output port and the slave input port.
interface master_out_port_if;
    import bus_pkg::*;

    logic                   master_valid;
    logic                   slave_ready;
    logic                   master_ready;
    logic                   tx_addr;
    logic                   tx_data;
    logic                   write_en;
    logic                   read_en;
    logic [BURST_WIDTH-1:0] burst;

    modport master (
        output master_valid, master_ready, tx_addr, tx_data, write_en, read_en, burst,
        input  slave_ready
    );

    modport slave (
        input  master_valid, master_ready, tx_addr, tx_data, write_en, read_en, burst,
        output slave_ready
    );
endinterface

// File: rtl/master_out_port_piso_shift.sv
// Parallel-load, LSB-first serialiser. Bit 0 appears on q the cycle after load;
// once the last bit has been shown, further shifts drive q low.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             q,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
            q   <= 1'b0;
        end else if (load) begin
            q   <= din[0];
            sr  <= din >> 1;
            cnt <= CW'(WIDTH - 1);
        end else if (shift) begin
            if (cnt != '0) begin
                q   <= sr[0];
                sr  <= sr >> 1;
                cnt <= cnt - CW'(1);
            end else begin
                q   <= 1'b0;
            end
        end
    end

    // High while the final bit (or nothing) is on q.
    assign done = (cnt == '0);
endmodule

// File: rtl/master_out_port.sv
// Master-side transmit port: handshakes each beat with the slave and serialises
// the address once and the write data per beat, LSB first.
module master_out_port
    import bus_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  addr_in,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [BURST_WIDTH-1:0] burst_in,
    input  logic                   write_in,
    input  logic                   read_in,
    input  logic                   rd_ready_in,
    output logic                   beat_ack,
    output logic                   busy,
    output logic                   done,
    master_out_port_if.master      bus
);
    state_t                    state, next;
    req_t                      req_q;
    logic [BURST_WIDTH-1:0]    burst_q;
    logic [BEAT_CNT_WIDTH-1:0] beat_cnt;
    logic                      master_ready_q;

    logic accept, hs, beat_inc, addr_shift, data_shift;
    logic addr_load, data_load, addr_done, data_done;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next;
    end

    always_comb begin
        next       = state;
        accept     = 1'b0;
        hs         = 1'b0;
        beat_inc   = 1'b0;
        addr_shift = 1'b0;
        data_shift = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (write_in || read_in)) begin
                    accept = 1'b1;
                    next   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.slave_ready) begin
                    hs   = 1'b1;
                    next = ST_SEND;
                end
            end
            ST_SEND: begin
                addr_shift = 1'b1;
                data_shift = 1'b1;
                if (addr_done) begin
                    if (burst_q[BURST_EN] && req_q.write && (burst_len(burst_q) != '0))
                        next = ST_BURST_REQ;
                    else
                        next = ST_DONE;
                end
            end
            ST_BURST_REQ: begin
                if (bus.slave_ready) begin
                    hs       = 1'b1;
                    beat_inc = 1'b1;
                    next     = ST_BURST_SEND;
                end
            end
            ST_BURST_SEND: begin
                data_shift = 1'b1;
                // Count is compared before it could ever step past the length.
                if (data_done)
                    next = (beat_cnt == burst_len(burst_q)) ? ST_DONE : ST_BURST_REQ;
            end
            ST_DONE: next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    assign addr_load = hs && (state == ST_REQ);
    assign data_load = hs && req_q.write;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q          <= '0;
            burst_q        <= '0;
            beat_cnt       <= '0;
            beat_ack       <= 1'b0;
            master_ready_q <= 1'b0;
        end else begin
            beat_ack       <= data_load;
            master_ready_q <= rd_ready_in;
            if (accept) begin
                req_q.addr  <= addr_in;
                req_q.write <= write_in;
                req_q.read  <= read_in & ~write_in;
                burst_q     <= burst_in;
                beat_cnt    <= '0;
            end else if (state == ST_DONE) begin
                req_q   <= '0;
                burst_q <= '0;
            end
            if (beat_inc) beat_cnt <= beat_cnt + BEAT_CNT_WIDTH'(1);
        end
    end

    piso_shift #(.WIDTH(ADDR_WIDTH)) u_addr_sh (
        .clk   (clk),
        .reset (reset),
        .load  (addr_load),
        .shift (addr_shift),
        .din   (req_q.addr),
        .q     (bus.tx_addr),
        .done  (addr_done)
    );

    piso_shift #(.WIDTH(DATA_WIDTH)) u_data_sh (
        .clk   (clk),
        .reset (reset),
        .load  (data_load),
        .shift (data_shift),
        .din   (data_in),
        .q     (bus.tx_data),
        .done  (data_done)
    );

    assign bus.master_valid = (state == ST_REQ) || (state == ST_BURST_REQ);
    assign bus.master_ready = master_ready_q;
    assign bus.write_en     = req_q.write;
    assign bus.read_en      = req_q.read;
    assign bus.burst        = burst_q;
    assign busy             = (state != ST_IDLE);
    assign done             = (state == ST_DONE);
endmodule

// File: tb/tb_master_out_port.sv
// Directed bench for master_out_port: reset, single write/read, stall, burst,
// priority/busy rules and mid-transfer reset.
module tb_master_out_port;
    import bus_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset, start, write_in, read_in, rd_ready_in;
    logic [ADDR_WIDTH-1:0]  addr_in;
    logic [DATA_WIDTH-1:0]  data_in;
    logic [BURST_WIDTH-1:0] burst_in;
    logic                   beat_ack, busy, done;
    int                     tests = 0;
    int                     fails = 0;

    master_out_port_if bus_i();

    master_out_port dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .addr_in     (addr_in),
        .data_in     (data_in),
        .burst_in    (burst_in),
        .write_in    (write_in),
        .read_in     (read_in),
        .rd_ready_in (rd_ready_in),
        .beat_ack    (beat_ack),
        .busy        (busy),
        .done        (done),
        .bus         (bus_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] o;
        reset = 1'b1; start = 1'b0; write_in = 1'b0; read_in = 1'b0; rd_ready_in = 1'b0;
        addr_in = '0; data_in = '0; burst_in = '0; bus_i.slave_ready = 1'b0;
        tick(); tick();
        o = {bus_i.master_valid, bus_i.master_ready, bus_i.tx_addr, bus_i.tx_data,
             bus_i.write_en, bus_i.read_en, beat_ack, busy, done};
        tests++;
        if (o !== 9'b0 || bus_i.burst !== 13'h0) begin
            fails++; $display("FAIL reset_outputs got=%b burst=%h want=0", o, bus_i.burst);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        logic [11:0] a;
        logic [7:0]  d;
        logic [3:0]  got, want;
        a = 12'hA5C; d = 8'h3C;
        addr_in = a; data_in = d; write_in = 1'b1; read_in = 1'b0; burst_in = '0;
        bus_i.slave_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; write_in = 1'b0;
        tests++;
        if ({bus_i.master_valid, busy, bus_i.write_en, bus_i.read_en} !== 4'b1110) begin
            fails++; $display("FAIL wr_req got=%b want=1110",
                              {bus_i.master_valid, busy, bus_i.write_en, bus_i.read_en});
        end
        tick();
        for (int k = 0; k < 12; k++) begin
            got  = {bus_i.tx_addr, bus_i.tx_data, beat_ack, done | bus_i.master_valid};
            want = {a[k], (k < 8) ? d[k] : 1'b0, (k == 0), 1'b0};
            tests++;
            if (got !== want) begin
                fails++; $display("FAIL wr_bit%0d got=%b want=%b", k, got, want);
            end
            tick();
        end
        tests++;
        if ({done, bus_i.write_en, busy} !== 3'b111) begin
            fails++; $display("FAIL wr_done got=%b want=111", {done, bus_i.write_en, busy});
        end
        tick();
        tests++;
        if ({done, bus_i.write_en, busy} !== 3'b000) begin
            fails++; $display("FAIL wr_idle got=%b want=000", {done, bus_i.write_en, busy});
        end
    endtask

    task automatic test_read();
        logic [11:0] a;
        logic [2:0]  got, want;
        a = 12'h001;
        rd_ready_in = 1'b1;
        tests++;
        if (bus_i.master_ready !== 1'b0) begin
            fails++; $display("FAIL mready_delay got=%b want=0", bus_i.master_ready);
        end
        addr_in = a; read_in = 1'b1; write_in = 1'b0; start = 1'b1; bus_i.slave_ready = 1'b1;
        tick();
        start = 1'b0; read_in = 1'b0;
        tests++;
        if ({bus_i.read_en, bus_i.write_en, bus_i.master_ready, bus_i.master_valid} !== 4'b1011) begin
            fails++; $display("FAIL rd_req got=%b want=1011",
                              {bus_i.read_en, bus_i.write_en, bus_i.master_ready, bus_i.master_valid});
        end
        tick();
        for (int k = 0; k < 12; k++) begin
            got  = {bus_i.tx_addr, bus_i.tx_data, beat_ack | done};
            want = {a[k], 1'b0, 1'b0};
            tests++;
            if (got !== want) begin
                fails++; $display("FAIL rd_bit%0d got=%b want=%b", k, got, want);
            end
            tick();
        end
        tests++;
        if ({done, bus_i.read_en} !== 2'b11) begin
            fails++; $display("FAIL rd_done got=%b want=11", {done, bus_i.read_en});
        end
        rd_ready_in = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic [11:0] a;
        logic [7:0]  d;
        a = 12'h0F0; d = 8'hA5;
        addr_in = a; data_in = d; write_in = 1'b1; start = 1'b1; bus_i.slave_ready = 1'b0;
        tick();
        start = 1'b0; write_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if ({bus_i.master_valid, bus_i.tx_addr, bus_i.tx_data, beat_ack} !== 4'b1000) begin
                fails++; $display("FAIL stall_c%0d got=%b want=1000", c,
                                  {bus_i.master_valid, bus_i.tx_addr, bus_i.tx_data, beat_ack});
            end
            tick();
        end
        bus_i.slave_ready = 1'b1;
        tick();
        tests++;
        if ({bus_i.master_valid, bus_i.tx_addr, bus_i.tx_data, beat_ack} !== {1'b0, a[0], d[0], 1'b1}) begin
            fails++; $display("FAIL stall_hs got=%b want=%b",
                              {bus_i.master_valid, bus_i.tx_addr, bus_i.tx_data, beat_ack},
                              {1'b0, a[0], d[0], 1'b1});
        end
        for (int k = 0; k < 12; k++) tick();
        tests++;
        if (done !== 1'b1) begin
            fails++; $display("FAIL stall_done got=%b want=1", done);
        end
        tick();
    endtask

    task automatic test_burst();
        logic [11:0] a;
        logic [7:0]  d;
        int          acks;
        a = 12'h123; d = 8'h11; acks = 0;
        addr_in = a; data_in = d; burst_in = 13'h005; write_in = 1'b1; start = 1'b1;
        bus_i.slave_ready = 1'b1;
        tick();
        start = 1'b0; write_in = 1'b0;
        tick();
        for (int k = 0; k < 12; k++) begin
            acks += int'(beat_ack);
            tests++;
            if ({bus_i.tx_addr, bus_i.tx_data} !== {a[k], (k < 8) ? d[k] : 1'b0}) begin
                fails++; $display("FAIL burst_b0_bit%0d got=%b", k, {bus_i.tx_addr, bus_i.tx_data});
            end
            if (k == 0) data_in = 8'h22;
            tick();
        end
        tests++;
        if ({bus_i.master_valid, done, bus_i.tx_addr, bus_i.tx_data} !== 4'b1000 ||
            bus_i.burst !== 13'h005) begin
            fails++; $display("FAIL burst_req1 got=%b burst=%h want=1000 005",
                              {bus_i.master_valid, done, bus_i.tx_addr, bus_i.tx_data}, bus_i.burst);
        end
        for (int b = 1; b < 3; b++) begin
            d = (b == 1) ? 8'h22 : 8'h33;
            tick();
            for (int j = 0; j < 8; j++) begin
                acks += int'(beat_ack);
                tests++;
                if ({bus_i.tx_addr, bus_i.tx_data, bus_i.master_valid} !== {1'b0, d[j], 1'b0}) begin
                    fails++; $display("FAIL burst_b%0d_bit%0d got=%b", b, j,
                                      {bus_i.tx_addr, bus_i.tx_data, bus_i.master_valid});
                end
                if (j == 0) data_in = 8'h33;
                tick();
            end
            tests++;
            if (b == 1 && {bus_i.master_valid, done} !== 2'b10) begin
                fails++; $display("FAIL burst_req2 got=%b want=10", {bus_i.master_valid, done});
            end else if (b == 2 && {bus_i.master_valid, done} !== 2'b01) begin
                fails++; $display("FAIL burst_done got=%b want=01", {bus_i.master_valid, done});
            end
        end
        tests++;
        if (acks !== 3) begin
            fails++; $display("FAIL burst_acks got=%0d want=3", acks);
        end
        burst_in = '0;
        tick();
    endtask

    task automatic test_priority_busy();
        start = 1'b1; write_in = 1'b0; read_in = 1'b0;
        tick();
        start = 1'b0;
        tests++;
        if ({busy, bus_i.master_valid} !== 2'b00) begin
            fails++; $display("FAIL no_cmd_start got=%b want=00", {busy, bus_i.master_valid});
        end
        addr_in = 12'h800; data_in = 8'h80; burst_in = 13'h001;
        write_in = 1'b1; read_in = 1'b1; bus_i.slave_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; write_in = 1'b0; read_in = 1'b0;
        tests++;
        if ({bus_i.write_en, bus_i.read_en} !== 2'b10 || bus_i.burst !== 13'h001) begin
            fails++; $display("FAIL wr_priority got=%b burst=%h want=10 001",
                              {bus_i.write_en, bus_i.read_en}, bus_i.burst);
        end
        addr_in = 12'h000; burst_in = 13'h1FFE; read_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; read_in = 1'b0;
        tests++;
        if ({bus_i.master_valid, bus_i.write_en, bus_i.read_en} !== 3'b110 || bus_i.burst !== 13'h001) begin
            fails++; $display("FAIL start_busy got=%b burst=%h want=110 001",
                              {bus_i.master_valid, bus_i.write_en, bus_i.read_en}, bus_i.burst);
        end
        bus_i.slave_ready = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) tick();
        tests++;
        if ({done, bus_i.master_valid} !== 2'b10) begin
            fails++; $display("FAIL single_beat_burst got=%b want=10", {done, bus_i.master_valid});
        end
        burst_in = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [11:0] a;
        logic [9:0]  o;
        int          dones;
        a = 12'hFFF; dones = 0;
        addr_in = a; data_in = 8'hFF; write_in = 1'b1; burst_in = 13'h003; start = 1'b1;
        bus_i.slave_ready = 1'b1;
        tick();
        start = 1'b0; write_in = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) tick();
        tests++;
        if (bus_i.tx_addr !== a[6]) begin
            fails++; $display("FAIL mid_bit6 got=%b want=%b", bus_i.tx_addr, a[6]);
        end
        reset = 1'b1;
        tick();
        o = {bus_i.master_valid, bus_i.master_ready, bus_i.tx_addr, bus_i.tx_data,
             bus_i.write_en, bus_i.read_en, beat_ack, busy, done, |bus_i.burst};
        tests++;
        if (o !== 10'b0) begin
            fails++; $display("FAIL mid_reset got=%b want=0", o);
        end
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            dones += int'(done);
            tick();
        end
        tests++;
        if (dones !== 0) begin
            fails++; $display("FAIL mid_no_done got=%0d want=0", dones);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_stall();
        test_burst();
        test_priority_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
